// File: rtl/mshr_pkg.sv
// Shared MSHR definitions: per-entry lifecycle encoding and default entry count.
package mshr_pkg;

   typedef enum logic [1:0] {
      FREE = 2'b00,
      RSVD = 2'b01,
      BUSY = 2'b10
   } mshr_entry_state_e;

   localparam int MSHR_ENTRY_NUM = 32;

endpackage

// File: rtl/mshr_entry_fsm.sv
// Lifecycle state of a single MSHR entry. Any event that does not match the
// current state is flagged and the entry holds its state.
module mshr_entry_fsm
   import mshr_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rsv_hit,
   input  logic              alloc_hit,
   input  logic              rel_hit,
   output mshr_entry_state_e state,
   output logic              illegal
);

   mshr_entry_state_e state_q;
   mshr_entry_state_e state_d;

   always_comb begin
      illegal = (rsv_hit   && (state_q != FREE)) ||
                (alloc_hit && (state_q != RSVD)) ||
                (rel_hit   && (state_q != BUSY));
      state_d = state_q;
      // The three legal events need mutually exclusive states, so at most one applies.
      if (!illegal) begin
         if (rsv_hit)        state_d = RSVD;
         else if (alloc_hit) state_d = BUSY;
         else if (rel_hit)   state_d = FREE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FREE;
      else        state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/mshr_entry_tracker.sv
// Tracks FREE/RSVD/BUSY for every MSHR entry, exports the free vector to the
// pre-allocator, keeps a free-entry count and a sticky protocol-error flag.
module mshr_entry_tracker
   import mshr_pkg::*;
#(
   parameter int ENTRY_NUM      = MSHR_ENTRY_NUM,
   parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic [ENTRY_NUM-1:0]      free_vld,
   input  logic [ENTRY_NUM-1:0]      rsv_oh,
   input  logic                      alloc_vld_0,
   input  logic [ENTRY_ID_WIDTH-1:0] alloc_idx_0,
   input  logic                      alloc_vld_1,
   input  logic [ENTRY_ID_WIDTH-1:0] alloc_idx_1,
   input  logic                      rel_vld,
   input  logic [ENTRY_ID_WIDTH-1:0] rel_idx,
   output logic [ENTRY_NUM-1:0]      busy_vec,
   output logic [ENTRY_ID_WIDTH:0]   free_cnt,
   output logic                      no_free,
   output logic                      err
);

   localparam int CNT_W = ENTRY_ID_WIDTH + 1;
   localparam logic [ENTRY_NUM-1:0] ONE = ENTRY_NUM'(1);

   logic [ENTRY_NUM-1:0] alloc_oh_0, alloc_oh_1, rel_oh;
   logic [ENTRY_NUM-1:0] rsv_hit, alloc_hit, entry_ill, rsv_ok, rel_ok;
   logic                 alloc_dup, rsv_over, idx_oob;
   logic [CNT_W-1:0]     rsv_raw_n, rsv_ok_n;
   logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
   logic                 err_q, err_d;
   mshr_entry_state_e    state_w [ENTRY_NUM];

   // Shifting past the vector width yields zero, so out-of-range indices hit nothing.
   assign alloc_oh_0 = alloc_vld_0 ? (ONE << alloc_idx_0) : '0;
   assign alloc_oh_1 = alloc_vld_1 ? (ONE << alloc_idx_1) : '0;
   assign rel_oh     = rel_vld     ? (ONE << rel_idx)     : '0;
   assign alloc_dup  = alloc_vld_0 && alloc_vld_1 && (alloc_idx_0 == alloc_idx_1);

   always_comb begin
      rsv_raw_n = '0;
      for (int i = 0; i < ENTRY_NUM; i++) rsv_raw_n += CNT_W'(rsv_oh[i]);
   end
   assign rsv_over = rsv_raw_n > CNT_W'(2);

   // Globally malformed requests are dropped entirely so no entry moves on them.
   assign rsv_hit   = rsv_over  ? '0 : rsv_oh;
   assign alloc_hit = alloc_dup ? '0 : (alloc_oh_0 | alloc_oh_1);

   generate
      if ((1 << ENTRY_ID_WIDTH) > ENTRY_NUM) begin : g_oob
         assign idx_oob = (alloc_vld_0 && (alloc_idx_0 >= ENTRY_ID_WIDTH'(ENTRY_NUM))) ||
                          (alloc_vld_1 && (alloc_idx_1 >= ENTRY_ID_WIDTH'(ENTRY_NUM))) ||
                          (rel_vld     && (rel_idx     >= ENTRY_ID_WIDTH'(ENTRY_NUM)));
      end else begin : g_no_oob
         assign idx_oob = 1'b0;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
         mshr_entry_fsm u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .rsv_hit   (rsv_hit[gi]),
            .alloc_hit (alloc_hit[gi]),
            .rel_hit   (rel_oh[gi]),
            .state     (state_w[gi]),
            .illegal   (entry_ill[gi])
         );
         assign free_vld[gi] = (state_w[gi] == FREE);
         assign busy_vec[gi] = (state_w[gi] == BUSY);
         assign rsv_ok[gi]   = rsv_hit[gi] & ~entry_ill[gi];
         assign rel_ok[gi]   = rel_oh[gi]  & ~entry_ill[gi];
      end
   endgenerate

   always_comb begin
      rsv_ok_n = '0;
      for (int i = 0; i < ENTRY_NUM; i++) rsv_ok_n += CNT_W'(rsv_ok[i]);
   end

   assign free_cnt_d = free_cnt_q - rsv_ok_n + CNT_W'(|rel_ok);
   assign err_d      = err_q | (|entry_ill) | alloc_dup | rsv_over | idx_oob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_cnt_q <= CNT_W'(ENTRY_NUM);
         err_q      <= 1'b0;
      end else begin
         free_cnt_q <= free_cnt_d;
         err_q      <= err_d;
      end
   end

   assign free_cnt = free_cnt_q;
   assign no_free  = (free_cnt_q == '0);
   assign err      = err_q;

endmodule

// File: tb/tb_mshr_entry_tracker.sv
// Scoreboard bench: the driver pushes expectations from an entry-state model,
// a monitor compares them against the DUT after every clock edge.
module tb_mshr_entry_tracker;

   localparam int N = 32;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] free_vld, busy_vec;
   logic [N-1:0] rsv_oh = '0;
   logic         alloc_vld_0 = 1'b0, alloc_vld_1 = 1'b0, rel_vld = 1'b0;
   logic [W-1:0] alloc_idx_0 = '0, alloc_idx_1 = '0, rel_idx = '0;
   logic [W:0]   free_cnt;
   logic         no_free, err;

   typedef struct {
      logic [N-1:0] fv;
      logic [N-1:0] bv;
      int           cnt;
      bit           nf;
      bit           er;
      int           id;
   } exp_t;

   exp_t exp_q[$];
   int   st[N];          // 0 = free, 1 = reserved, 2 = busy
   bit   m_err;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   txn      = 0;

   always #5 clk = ~clk;

   mshr_entry_tracker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .free_vld    (free_vld),
      .rsv_oh      (rsv_oh),
      .alloc_vld_0 (alloc_vld_0),
      .alloc_idx_0 (alloc_idx_0),
      .alloc_vld_1 (alloc_vld_1),
      .alloc_idx_1 (alloc_idx_1),
      .rel_vld     (rel_vld),
      .rel_idx     (rel_idx),
      .busy_vec    (busy_vec),
      .free_cnt    (free_cnt),
      .no_free     (no_free),
      .err         (err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   function automatic logic [N-1:0] bit_of(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   // Reference model: each entry reacts only to the events that name it.
   task automatic model_apply(input logic [N-1:0] rsv, input bit a0, input int i0,
                              input bit a1, input int i1, input bit rl, input int ri);
      bit over, dup, r, a, l, bad;
      over = $countones(rsv) > 2;
      dup  = a0 && a1 && (i0 == i1);
      if (over || dup) m_err = 1'b1;
      for (int e = 0; e < N; e++) begin
         r   = rsv[e] && !over;
         a   = ((a0 && i0 == e) || (a1 && i1 == e)) && !dup;
         l   = rl && (ri == e);
         bad = (r && st[e] != 0) || (a && st[e] != 1) || (l && st[e] != 2);
         if (bad)    m_err = 1'b1;
         else if (r) st[e] = 1;
         else if (a) st[e] = 2;
         else if (l) st[e] = 0;
      end
   endtask

   task automatic step(input logic [N-1:0] rsv, input bit a0, input int i0,
                       input bit a1, input int i1, input bit rl, input int ri);
      exp_t e;
      @(negedge clk);
      rsv_oh      = rsv;
      alloc_vld_0 = a0;  alloc_idx_0 = W'(i0);
      alloc_vld_1 = a1;  alloc_idx_1 = W'(i1);
      rel_vld     = rl;  rel_idx     = W'(ri);
      model_apply(rsv, a0, i0, a1, i1, rl, ri);
      e.fv = '0; e.bv = '0; e.cnt = 0;
      for (int k = 0; k < N; k++) begin
         e.fv[k] = (st[k] == 0);
         e.bv[k] = (st[k] == 2);
         if (st[k] == 0) e.cnt++;
      end
      e.nf = (e.cnt == 0);
      e.er = m_err;
      txn++;
      e.id = txn;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      rsv_oh = '0; alloc_vld_0 = 1'b0; alloc_vld_1 = 1'b0; rel_vld = 1'b0;
   endtask

   task automatic rsv_step(input logic [N-1:0] r);
      step(r, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_free_vld", free_vld, 32'hFFFF_FFFF);
      chk("rst_busy_vec", busy_vec, 32'h0);
      chk("rst_free_cnt", 32'(free_cnt), 32'd32);
      chk("rst_no_free",  32'(no_free), 32'd0);
      chk("rst_err",      32'(err), 32'd0);
      $display("reset checked at %0t", $time);
      for (int k = 0; k < N; k++) st[k] = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_step(input bit inj);
      int fl[$], rl_q[$], bl[$];
      logic [N-1:0] rsv;
      bit a0, a1, rl;
      int i0, i1, ri, n, p, x;
      rsv = '0; a0 = 0; a1 = 0; rl = 0; i0 = 0; i1 = 0; ri = 0;
      for (int k = 0; k < N; k++) begin
         if (st[k] == 0)      fl.push_back(k);
         else if (st[k] == 1) rl_q.push_back(k);
         else                 bl.push_back(k);
      end
      n = $urandom_range(0, 2);
      for (int j = 0; j < n && fl.size() > 0; j++) begin
         p = $urandom_range(0, fl.size() - 1);
         rsv |= bit_of(fl[p]);
         fl.delete(p);
      end
      if (rl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
         p = $urandom_range(0, rl_q.size() - 1);
         a0 = 1; i0 = rl_q[p]; rl_q.delete(p);
      end
      if (rl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
         p = $urandom_range(0, rl_q.size() - 1);
         a1 = 1; i1 = rl_q[p]; rl_q.delete(p);
      end
      if (bl.size() > 0 && $urandom_range(0, 3) != 0) begin
         rl = 1; ri = bl[$urandom_range(0, bl.size() - 1)];
      end
      if (inj && $urandom_range(0, 7) == 0) begin
         x = $urandom_range(0, N - 1);
         case ($urandom_range(0, 4))
            0: rsv |= bit_of(x);
            1: rsv |= bit_of(x) | bit_of((x + 1) % N) | bit_of((x + 2) % N);
            2: begin a0 = 1; a1 = 1; i0 = x; i1 = x; end
            3: begin a0 = 1; i0 = x; end
            default: begin rl = 1; ri = x; end
         endcase
      end
      step(rsv, a0, i0, a1, i1, rl, ri);
   endtask

   // Monitor: the DUT presents fresh outputs after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("txn%0d_free_vld", e.id), free_vld, e.fv);
            chk($sformatf("txn%0d_busy_vec", e.id), busy_vec, e.bv);
            chk($sformatf("txn%0d_free_cnt", e.id), 32'(free_cnt), 32'(e.cnt));
            chk($sformatf("txn%0d_no_free", e.id),  32'(no_free), 32'(e.nf));
            chk($sformatf("txn%0d_err", e.id),      32'(err), 32'(e.er));
            $display("txn %0d free_vld=%h busy_vec=%h free_cnt=%0d no_free=%0b err=%0b",
                     e.id, free_vld, busy_vec, free_cnt, no_free, err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Full lifecycle of entry 3
      rsv_step(bit_of(3));
      step('0, 1, 3, 0, 0, 0, 0);
      step('0, 0, 0, 0, 0, 1, 3);

      // Dual reservation, dual allocation, release concurrent with reservations
      rsv_step(bit_of(0) | bit_of(1));
      step('0, 1, 0, 1, 1, 0, 0);
      rsv_step(bit_of(5));
      step('0, 1, 5, 0, 0, 0, 0);
      step(bit_of(6) | bit_of(7), 0, 0, 0, 0, 1, 5);

      // Exhaustion
      do_reset();
      for (int k = 0; k < 16; k++) rsv_step(bit_of(2 * k) | bit_of(2 * k + 1));
      step('0, 1, 0, 0, 0, 0, 0);
      step('0, 0, 0, 0, 0, 1, 0);
      rsv_step(bit_of(0));

      // Violations, each from a clean state
      do_reset();
      step('0, 0, 0, 0, 0, 1, 4);
      do_reset();
      rsv_step(bit_of(2) | bit_of(9));
      step('0, 1, 2, 1, 2, 0, 0);
      do_reset();
      rsv_step(bit_of(7));
      step('0, 1, 7, 0, 0, 0, 0);
      rsv_step(bit_of(7));

      // Asynchronous reset with 10 busy and 2 reserved entries
      do_reset();
      for (int k = 0; k < 6; k++) rsv_step(bit_of(2 * k) | bit_of(2 * k + 1));
      for (int k = 0; k < 5; k++) step('0, 1, 2 * k, 1, 2 * k + 1, 0, 0);
      do_reset();

      for (int k = 0; k < 150; k++) rand_step(1'b0);
      do_reset();
      for (int k = 0; k < 100; k++) rand_step(1'b1);

      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
